// File: rtl/fibo_engine.sv
// fibo_engine -- iterative Fibonacci / Lucas term generator.
//
// A single accepted Start loads the two seeds of the selected sequence and
// the requested index, then advances the pair (a, b) once per clock until
// the index counter reaches zero. At that point a holds the requested term;
// it is copied to Result and Done pulses for one cycle.
//
// Ports:
//   Clk      system clock, rising edge
//   Rst      asynchronous active-low reset
//   Start    request one term (only looked at while idle)
//   Clr      synchronous abort back to idle, wins over Start
//   Mode     0 = Fibonacci (seeds 0,1), 1 = Lucas (seeds 2,1)
//   N        index of the requested term
//   Result   requested term modulo 2^WIDTH, held until the next Done
//   Done     one-cycle pulse, Result/Overflow valid
//   Busy     high while a request is in flight
//   Overflow sticky: the true term did not fit in WIDTH bits
module fibo_engine #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Clr,
  input  logic             Mode,
  input  logic [CNT_W-1:0] N,
  output logic [WIDTH-1:0] Result,
  output logic             Done,
  output logic             Busy,
  output logic             Overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             start_acc;
  logic             step;
  logic             finish;

  // Unsigned add that wraps modulo 2^WIDTH and exposes the carry out.
  function automatic logic [WIDTH:0] add_wrap(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  assign {carry, sum} = add_wrap(a, b);
  assign Busy         = (state != IDLE);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    if (Clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            start_acc = 1'b1;
            state_nxt = CALC;
          end
        end
        CALC: begin
          if (cnt != '0) begin
            step = 1'b1;
          end else begin
            finish    = 1'b1;
            state_nxt = DONE;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath. After k steps, a = term(k) and b = term(k+1). The step taken
  // with cnt == 1 produces term(N+1), which is never reported, so its carry
  // must not flag Overflow.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      a        <= '0;
      b        <= '0;
      cnt      <= '0;
      Result   <= '0;
      Overflow <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= finish;
      if (start_acc) begin
        a        <= Mode ? WIDTH'(2) : '0;
        b        <= WIDTH'(1);
        cnt      <= N;
        Overflow <= 1'b0;
      end else if (step) begin
        a   <= b;
        b   <= sum;
        cnt <= cnt - CNT_W'(1);
        if (carry && (cnt > CNT_W'(1))) begin
          Overflow <= 1'b1;
        end
      end else if (finish) begin
        Result <= a;
      end
    end
  end

endmodule

// File: tb/tb_fibo_engine.sv
module tb_fibo_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic        clr;
  logic        mode;
  logic [5:0]  n;
  logic [15:0] result16;
  logic [7:0]  result8;
  logic        done16, done8, busy16, busy8, ovf16, ovf8;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  fibo_engine #(.WIDTH(16), .CNT_W(6)) u16 (
    .Clk(clk), .Rst(rst), .Start(start), .Clr(clr), .Mode(mode), .N(n),
    .Result(result16), .Done(done16), .Busy(busy16), .Overflow(ovf16)
  );

  fibo_engine #(.WIDTH(8), .CNT_W(6)) u8 (
    .Clk(clk), .Rst(rst), .Start(start), .Clr(clr), .Mode(mode), .N(n),
    .Result(result8), .Done(done8), .Busy(busy8), .Overflow(ovf8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Exact mathematical term of the sequence (no wrap).
  function automatic longint true_term(input bit m, input int idx);
    longint x, y, t;
    x = m ? 64'd2 : 64'd0;
    y = 64'd1;
    for (int i = 0; i < idx; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Reference model: request accepted from idle, answer appears N+1 edges
  // later for one cycle, then one idle-bound cycle.
  int          m_phase;   // 0 idle, 1 computing, 2 done cycle
  int          m_remain;
  bit          m_mode;
  int          m_n;
  bit          m_done;
  longint      m_r16, m_r8;
  bit          m_o16, m_o8;
  bit          m_known;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase  <= 0;
      m_remain <= 0;
      m_done   <= 0;
      m_r16    <= 0;
      m_r8     <= 0;
      m_o16    <= 0;
      m_o8     <= 0;
      m_known  <= 1;
    end else begin
      m_done <= 0;
      if (clr) begin
        m_phase <= 0;
      end else begin
        case (m_phase)
          0: if (start) begin
            m_phase  <= 1;
            m_remain <= int'(n) + 1;
            m_mode   <= mode;
            m_n      <= int'(n);
            m_known  <= 0;
          end
          1: begin
            m_remain <= m_remain - 1;
            if (m_remain == 1) begin
              m_phase <= 2;
              m_done  <= 1;
              m_r16   <= true_term(m_mode, m_n) % 65536;
              m_r8    <= true_term(m_mode, m_n) % 256;
              m_o16   <= (true_term(m_mode, m_n) >= 65536);
              m_o8    <= (true_term(m_mode, m_n) >= 256);
              m_known <= 1;
            end
          end
          default: m_phase <= 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy16", busy16, m_phase != 0);
      chk("busy8", busy8, m_phase != 0);
      chk("done16", done16, m_done);
      chk("done8", done8, m_done);
      chk("result16", result16, m_r16);
      chk("result8", result8, m_r8);
      if (m_known) begin
        chk("ovf16", ovf16, m_o16);
        chk("ovf8", ovf8, m_o8);
      end
    end
  end

  // Leaves the bench just after the Start-sampling edge (edge 0).
  task automatic launch(input bit m, input int idx);
    @(posedge clk);
    #2;
    start = 1'b1;
    mode  = m;
    n     = 6'(idx);
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  // Counts edges after edge `elapsed` until Done, then pins the outputs.
  task automatic wait_done(input string tag, input int elapsed, input int exp_lat,
                           input longint e16, input longint e8,
                           input bit eo16, input bit eo8);
    int lat;
    lat = -1;
    for (int k = elapsed + 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (done16) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_r16"}, result16, e16);
    chk({tag, "_r8"}, result8, e8);
    chk({tag, "_o16"}, ovf16, eo16);
    chk({tag, "_o8"}, ovf8, eo8);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    clr   = 1'b0;
    mode  = 1'b0;
    n     = '0;
    #1 rst = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result16", result16, 0);
    chk("rst_done", done16, 0);
    chk("rst_busy", busy16, 0);
    chk("rst_ovf", ovf16, 0);
    #1 rst = 1'b1;

    // Fibonacci N=10, Busy rises right after the sampling edge
    launch(0, 10);
    chk("fib10_busy", busy16, 1);
    wait_done("fib10", 0, 11, 55, 55, 0, 0);

    // Lucas sequence
    launch(1, 10);
    wait_done("luc10", 0, 11, 123, 123, 0, 0);
    launch(1, 0);
    wait_done("luc0", 0, 1, 2, 2, 0, 0);
    launch(0, 0);
    wait_done("fib0", 0, 1, 0, 0, 0, 0);
    launch(0, 1);
    wait_done("fib1", 0, 2, 1, 1, 0, 0);

    // 8-bit overflow boundary
    launch(0, 13);
    wait_done("fib13", 0, 14, 233, 233, 0, 0);
    launch(0, 14);
    wait_done("fib14", 0, 15, 377, 121, 0, 1);

    // Start and N disturbed mid-computation
    launch(0, 10);
    @(posedge clk);
    #2;
    start = 1'b1;
    n     = 6'd3;
    mode  = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done("fib10_dist", 2, 11, 55, 55, 0, 0);

    // Start held high through the done cycle, re-accepted on first idle edge
    @(posedge clk);
    #2;
    start = 1'b1;
    mode  = 1'b0;
    n     = 6'd2;
    @(posedge clk);
    wait_done("held_a", 0, 3, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    chk("held_gap_busy", busy16, 0);
    #1;
    n = 6'd3;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done("held_b", 0, 4, 2, 2, 0, 0);

    // Clear mid-computation
    launch(0, 12);
    wait_done("fib12", 0, 13, 144, 144, 0, 0);
    launch(0, 20);
    repeat (2) @(posedge clk);
    #2;
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_busy", busy16, 0);
    chk("clr_done", done16, 0);
    chk("clr_result", result16, 144);
    chk("clr_ovf", ovf16, 0);
    chk("clr_ovf8", ovf8, 0);
    #1;
    clr = 1'b0;
    repeat (3) @(posedge clk);
    launch(0, 5);
    wait_done("fib5", 0, 6, 5, 5, 0, 0);

    // Clear beats Start while idle
    @(posedge clk);
    #2;
    start = 1'b1;
    clr   = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_prio_busy", busy16, 0);
    #1;
    start = 1'b0;
    clr   = 1'b0;

    // Asynchronous reset mid-computation
    launch(0, 20);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_result16", result16, 0);
    chk("arst_result8", result8, 0);
    chk("arst_busy", busy16, 0);
    chk("arst_done", done16, 0);
    chk("arst_ovf", ovf16, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    launch(0, 1);
    wait_done("post_rst", 0, 2, 1, 1, 0, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
